// File: rtl/wb_master_port.sv
// Wishbone classic single-transfer initiator: one WB read or write per command,
// with big-endian lane steering, misalignment checks, bus-error and watchdog reporting.
module wb_master_port #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [1:0]  cmd_size_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_addr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] data_q, data_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  cmdSel;
    logic [31:0] cmdWdata;
    logic [31:0] laneData;

    assign accept  = cmd_valid_i & ready_q;
    assign timeout = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Command decode: alignment check plus big-endian select and write-data replication.
    always_comb begin
        misaligned = 1'b0;
        cmdSel     = 4'b1111;
        cmdWdata   = cmd_wdata_i;
        case (cmd_size_i)
            2'b00: begin
                cmdSel   = 4'b1000 >> cmd_addr_i[1:0];
                cmdWdata = {4{cmd_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = cmd_addr_i[0];
                cmdSel     = cmd_addr_i[1] ? 4'b0011 : 4'b1100;
                cmdWdata   = {2{cmd_wdata_i[15:0]}};
            end
            2'b10: misaligned = |cmd_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        case (sel_q)
            4'b1000: laneData = {24'b0, wb_data_i[31:24]};
            4'b0100: laneData = {24'b0, wb_data_i[23:16]};
            4'b0010: laneData = {24'b0, wb_data_i[15:8]};
            4'b0001: laneData = {24'b0, wb_data_i[7:0]};
            4'b1100: laneData = {16'b0, wb_data_i[31:16]};
            4'b0011: laneData = {16'b0, wb_data_i[15:0]};
            default: laneData = wb_data_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = misaligned ? RESP : BUS;
            BUS:  if (wb_err_i || wb_ack_i || timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Error outranks a simultaneous ack; the watchdog only fires when neither arrives.
    always_comb begin
        ready_d     = (state_d == IDLE);
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        cyc_d  = 1'b1;
                        we_d   = cmd_we_i;
                        addr_d = {cmd_addr_i[31:2], 2'b00};
                        sel_d  = cmdSel;
                        data_d = cmdWdata;
                        cnt_d  = '0;
                    end
                end
            end
            BUS: begin
                cnt_d = cnt_q + TO_W'(1);
                if (wb_err_i || (!wb_ack_i && timeout)) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'b0 : laneData;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q     <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'b0;
            sel_q       <= 4'b0;
            data_q      <= 32'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
        end else begin
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_sel_o    = sel_q;
    assign wb_data_o   = data_q;

endmodule
